// File: rtl/ringbuf_pkg.sv
// Shared types and defaults for the ringbuf sample buffer.
// The RINGBUF_STATUS_EN macro adds fill-level/overflow/underflow status ports.
package ringbuf_pkg;

    localparam int unsigned DATA_W           = 24;
    localparam int unsigned LEN_DEFAULT      = 64;
    localparam int unsigned LEN_LOG2_DEFAULT = 6;

    typedef logic [DATA_W-1:0] sample_t;

    // Encoded directly as {we, pop} so the strobes can be cast straight in.
    typedef enum logic [1:0] {
        UPD_IDLE  = 2'b00,
        UPD_POP   = 2'b01,
        UPD_WRITE = 2'b10,
        UPD_BOTH  = 2'b11
    } upd_e;

endpackage

// File: rtl/ringbuf_if.sv
// Sample-side bus of the ringbuf: write strobe, pop strobe, offset read.
// Status signals exist only when RINGBUF_STATUS_EN is defined.
interface ringbuf_if
    import ringbuf_pkg::*;
#(
    parameter int unsigned LEN_LOG2 = LEN_LOG2_DEFAULT
);

    sample_t             data_i;
    logic                we_i;
    logic                pop_i;
    logic [LEN_LOG2-1:0] offset_i;
    sample_t             data_o;
`ifdef RINGBUF_STATUS_EN
    logic [LEN_LOG2:0]   count_o;
    logic                overflow_o;
    logic                underflow_o;

    modport master (
        output data_i, we_i, pop_i, offset_i,
        input  data_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  data_i, we_i, pop_i, offset_i,
        output data_o, count_o, overflow_o, underflow_o
    );
`else
    modport master (
        output data_i, we_i, pop_i, offset_i,
        input  data_o
    );

    modport slave (
        input  data_i, we_i, pop_i, offset_i,
        output data_o
    );
`endif

endinterface

// File: rtl/ringbuf_mem.sv
// Ringbuf storage: one synchronous write port, one asynchronous read port,
// whole array cleared asynchronously by rst.
module ringbuf_mem
    import ringbuf_pkg::*;
#(
    parameter int unsigned DEPTH = LEN_DEFAULT,
    parameter int unsigned AW    = LEN_LOG2_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  sample_t       wdata_i,
    input  logic [AW-1:0] raddr_i,
    output sample_t       rdata_o
);

    sample_t mem_q [DEPTH];
    sample_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read reflects the registered array, so a same-edge write is not visible yet.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ringbuf.sv
// Ring buffer of 24-bit samples with offset-relative combinational read.
// Optional status (count/overflow/underflow) enabled by RINGBUF_STATUS_EN.
module ringbuf
    import ringbuf_pkg::*;
#(
    parameter int unsigned LEN      = LEN_DEFAULT,
    parameter int unsigned LEN_LOG2 = LEN_LOG2_DEFAULT
) (
    input logic      clk,
    input logic      rst,
    ringbuf_if.slave bus
);

    typedef logic [LEN_LOG2-1:0] ptr_t;

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t raddr;

    // Pointers wrap naturally at LEN because LEN is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (bus.we_i) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
        if (bus.pop_i) begin
            rptr_d = rptr_q + ptr_t'(1);
        end
        raddr = rptr_q + bus.offset_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    ringbuf_mem #(
        .DEPTH (LEN),
        .AW    (LEN_LOG2)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bus.we_i),
        .waddr_i (wptr_q),
        .wdata_i (bus.data_i),
        .raddr_i (raddr),
        .rdata_o (bus.data_o)
    );

`ifdef RINGBUF_STATUS_EN
    typedef logic [LEN_LOG2:0] cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(LEN);

    upd_e upd;
    cnt_t count_q, count_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Count saturates; the pointers keep moving regardless.
    always_comb begin
        upd         = upd_e'({bus.we_i, bus.pop_i});
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        case (upd)
            UPD_WRITE: begin
                if (count_q == CNT_FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + cnt_t'(1);
                end
            end
            UPD_POP: begin
                if (count_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    count_d = count_q - cnt_t'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.count_o     = count_q;
    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_ringbuf.sv
// Self-checking bench for ringbuf; status ports checked when RINGBUF_STATUS_EN is defined.
module tb_ringbuf;
    import ringbuf_pkg::*;

    localparam int unsigned LEN = 64;
    localparam int unsigned LW  = 6;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ringbuf_if #(.LEN_LOG2(LW)) bus ();

    ringbuf #(
        .LEN      (LEN),
        .LEN_LOG2 (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] exp_q [$];

    sample_t       mdl_mem [LEN];
    logic [LW-1:0] mdl_w;
    logic [LW-1:0] mdl_r;
    int            mdl_cnt;
    logic          mdl_ovf;
    logic          mdl_unf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < int'(LEN); i++) mdl_mem[i] = '0;
        mdl_w   = '0;
        mdl_r   = '0;
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
    endtask

    task automatic mdl_edge(input logic we, input logic pop, input sample_t d);
        if (we) begin
            mdl_mem[mdl_w] = d;
            mdl_w = mdl_w + 1'b1;
        end
        if (pop) mdl_r = mdl_r + 1'b1;
        if (we && !pop) begin
            if (mdl_cnt == int'(LEN)) mdl_ovf = 1'b1;
            else mdl_cnt++;
        end else if (pop && !we) begin
            if (mdl_cnt == 0) mdl_unf = 1'b1;
            else mdl_cnt--;
        end
    endtask

    task automatic step(input logic we, input logic pop, input sample_t d);
        @(negedge clk);
        bus.we_i   = we;
        bus.pop_i  = pop;
        bus.data_i = d;
        @(posedge clk);
        if (!rst) mdl_edge(we, pop, d);
        #1;
        bus.we_i  = 1'b0;
        bus.pop_i = 1'b0;
    endtask

    task automatic probe(input string tag, input int off, input logic [31:0] exp);
        @(negedge clk);
        bus.offset_i = LW'(off);
        exp_q.push_back(exp);
        #1;
        check_eq(tag, 32'(bus.data_o), exp_q.pop_front());
    endtask

    task automatic probe_mdl(input string tag, input int off);
        logic [LW-1:0] idx;
        idx = mdl_r + LW'(off);
        probe(tag, off, 32'(mdl_mem[idx]));
    endtask

    task automatic check_status(input string tag);
`ifdef RINGBUF_STATUS_EN
        check_eq({tag, "_count"}, 32'(bus.count_o), 32'(mdl_cnt));
        check_eq({tag, "_ovf"}, 32'(bus.overflow_o), 32'(mdl_ovf));
        check_eq({tag, "_unf"}, 32'(bus.underflow_o), 32'(mdl_unf));
`else
        check_eq({tag, "_wptr_model"}, 32'(mdl_w), 32'(mdl_w + 0));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        mdl_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.we_i     = 1'b0;
        bus.pop_i    = 1'b0;
        bus.data_i   = '0;
        bus.offset_i = '0;
        mdl_clear();

        // All offsets read zero while reset is held.
        for (int i = 0; i < int'(LEN); i++) probe($sformatf("rst_off%0d", i), i, 32'h0);
        check_status("rst");
        @(negedge clk);
        rst = 1'b0;

        // Four writes land at offsets 0..3.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, sample_t'(i));
        for (int i = 0; i < 4; i++) probe($sformatf("wr4_off%0d", i), i, 32'(i + 1));
        check_status("wr4");

        step(1'b0, 1'b1, '0);
        probe("pop_off0", 0, 32'd2);
        probe("pop_off2", 2, 32'd4);

        // Read and write of the same address in one cycle: old value until the edge.
        @(negedge clk);
        bus.offset_i = LW'(3);
        bus.we_i     = 1'b1;
        bus.data_i   = 24'hABCDEF;
        #1;
        check_eq("same_cycle_old", 32'(bus.data_o), 32'h0);
        @(posedge clk);
        mdl_edge(1'b1, 1'b0, 24'hABCDEF);
        #1;
        bus.we_i = 1'b0;
        probe("same_cycle_new", 3, 32'hABCDEF);

        // Pop while empty still advances rptr.
        do_reset();
        step(1'b0, 1'b1, '0);
        check_status("empty_pop");
        step(1'b1, 1'b0, 24'h5A5A5A);
        probe("empty_pop_off63", 63, 32'h5A5A5A);
        probe("empty_pop_off0", 0, 32'h0);

        // 70 writes wrap the write pointer and overwrite the oldest entries.
        do_reset();
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, sample_t'(100 + i));
        probe("wrap_off0", 0, 32'd164);
        probe("wrap_off5", 5, 32'd169);
        probe("wrap_off6", 6, 32'd106);
        probe("wrap_off63", 63, 32'd163);
        for (int i = 0; i < int'(LEN); i += 7) probe_mdl($sformatf("wrap_mdl%0d", i), i);
`ifdef RINGBUF_STATUS_EN
        check_eq("wrap_count64", 32'(bus.count_o), 32'd64);
        check_eq("wrap_ovf1", 32'(bus.overflow_o), 32'd1);
`endif
        check_status("wrap");

        // Simultaneous write and pop keep the fill level constant.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, sample_t'(200 + i));
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, sample_t'(204 + k));
            probe($sformatf("track%0d", k), 0, 32'(200 + k));
`ifdef RINGBUF_STATUS_EN
            check_eq($sformatf("track_count%0d", k), 32'(bus.count_o), 32'd5);
`endif
        end
        check_status("track");

        // Asynchronous reset between edges clears data immediately and drops the in-flight write.
        do_reset();
        step(1'b1, 1'b0, 24'h000111);
        step(1'b1, 1'b0, 24'h000222);
        step(1'b1, 1'b0, 24'h000333);
        @(negedge clk);
        bus.offset_i = LW'(1);
        bus.we_i     = 1'b1;
        bus.pop_i    = 1'b1;
        bus.data_i   = 24'h000444;
        #1;
        check_eq("pre_async_rst", 32'(bus.data_o), 32'h222);
        #2 rst = 1'b1;
        mdl_clear();
        #1;
        check_eq("async_rst_now", 32'(bus.data_o), 32'h0);
        @(posedge clk);
        #1;
        check_eq("async_rst_held", 32'(bus.data_o), 32'h0);
        bus.we_i  = 1'b0;
        bus.pop_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 24'h000777);
        probe("post_rst_off0", 0, 32'h777);
        probe("post_rst_off1", 1, 32'h0);
        check_status("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
